// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one async_mem port between two requesters,
// with fixed read wait states and registered, per-port read data.
module mem_port_arbiter #(
  parameter int READ_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic        grant
);

  typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(READ_WAIT - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        last_grant, last_grant_n;
  logic        grant_n, sel;
  logic        mem_read_n, mem_write_n, ack0_n, ack1_n, busy_n;
  logic [31:0] mem_addr_n, mem_write_data_n, rdata0_n, rdata1_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      last_grant     <= 1'b1;
      grant          <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      busy           <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      rdata0         <= '0;
      rdata1         <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      last_grant     <= last_grant_n;
      grant          <= grant_n;
      mem_read       <= mem_read_n;
      mem_write      <= mem_write_n;
      ack0           <= ack0_n;
      ack1           <= ack1_n;
      busy           <= busy_n;
      mem_addr       <= mem_addr_n;
      mem_write_data <= mem_write_data_n;
      rdata0         <= rdata0_n;
      rdata1         <= rdata1_n;
    end
  end

  // Every output is a register; this block computes the value each one takes
  // at the next edge so strobes and acks line up with the state they belong to.
  always_comb begin
    state_n          = state;
    cnt_n            = cnt;
    last_grant_n     = last_grant;
    grant_n          = grant;
    mem_addr_n       = mem_addr;
    mem_write_data_n = mem_write_data;
    rdata0_n         = rdata0;
    rdata1_n         = rdata1;
    mem_read_n       = 1'b0;
    mem_write_n      = 1'b0;
    ack0_n           = 1'b0;
    ack1_n           = 1'b0;
    sel              = (req0 && req1) ? ~last_grant : req1;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_n          = sel;
          mem_addr_n       = sel ? addr1 : addr0;
          mem_write_data_n = sel ? wdata1 : wdata0;
          if (sel ? we1 : we0) begin
            state_n     = WR;
            mem_write_n = 1'b1;
          end else begin
            state_n    = RD;
            mem_read_n = 1'b1;
            cnt_n      = CNT_LOAD;
          end
        end
      end
      RD: begin
        if (cnt == 4'd0) begin
          if (grant) rdata1_n = mem_read_data;
          else       rdata0_n = mem_read_data;
          ack0_n  = ~grant;
          ack1_n  = grant;
          state_n = ACK;
        end else begin
          cnt_n      = cnt - 4'd1;
          mem_read_n = 1'b1;
        end
      end
      WR: begin
        ack0_n  = ~grant;
        ack1_n  = grant;
        state_n = ACK;
      end
      ACK: begin
        last_grant_n = grant;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule
